// File: rtl/cte_stream_driver.sv
// Host-side initiator for the colour-transform engine: buffers a tagged pixel stream,
// feeds the CTE under busy/credit control and queues every CTE result for downstream.
module cte_stream_driver #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_mode,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        op_mode,
  output logic        in_en,
  output logic [7:0]  yuv_in,
  output logic [23:0] rgb_in,
  input  logic        busy,
  input  logic        out_valid,
  input  logic [23:0] rgb_out,
  input  logic [7:0]  yuv_out,
  output logic        err
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int PW  = OAW + 1;
  localparam logic [PW:0]  DEPTH_W = (PW+1)'(OUT_DEPTH);
  localparam logic [IAW:0] IN_ONE  = (IAW+1)'(1);
  localparam logic [OAW:0] OUT_ONE = (OAW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          op_mode_q, op_mode_d;
  logic          in_en_q, in_en_d;
  logic [7:0]    yuv_in_q, yuv_in_d;
  logic [23:0]   rgb_in_q, rgb_in_d;
  logic          err_q, err_d;
  logic [1:0]    phase_q, phase_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [IAW:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OAW:0]  out_wr_q, out_wr_d, out_rd_q, out_rd_d;

  logic [24:0]   in_mem_q [IN_DEPTH];
  logic [23:0]   out_mem_q [OUT_DEPTH];

  logic          in_empty, in_full, in_push, issue;
  logic [24:0]   head;
  logic          head_mode;
  logic          out_empty, out_pop;
  logic [OAW:0]  out_occ;
  logic [PW:0]   out_free, need;
  logic [PW-1:0] add;
  logic          closing, credit_ok;
  logic [23:0]   cap_data;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                     (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_push   = s_valid && !in_full;
  assign head      = in_mem_q[in_rd_q[IAW-1:0]];
  assign head_mode = head[24];

  assign out_empty = (out_wr_q == out_rd_q);
  assign out_pop   = !out_empty && m_ready;
  assign out_occ   = out_wr_q - out_rd_q;
  assign out_free  = DEPTH_W - {1'b0, out_occ};
  assign cap_data  = op_mode_q ? {16'h0, yuv_out} : rgb_out;

  // Results a single issue of the head word would add; a mode-1 pixel or the
  // second half of a 4:2:2 group closes a group and needs a gap afterwards.
  always_comb begin
    if (op_mode_q) begin
      add     = PW'(2);
      closing = 1'b1;
    end else begin
      add     = PW'(phase_q[1]);
      closing = phase_q[1];
    end
  end

  assign need      = {1'b0, pending_q} + {1'b0, add};
  assign credit_ok = (out_free >= need);

  always_comb begin
    state_d   = state_q;
    op_mode_d = op_mode_q;
    in_en_d   = 1'b0;
    yuv_in_d  = yuv_in_q;
    rgb_in_d  = rgb_in_q;
    phase_d   = phase_q;
    err_d     = err_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_empty) begin
          if (head_mode == op_mode_q) begin
            state_d = RUN;
          end else begin
            state_d = DRAIN;
            err_d   = err_q | (phase_q != 2'd0);
          end
        end
      end
      RUN: begin
        if (in_empty) begin
          state_d = IDLE;
        end else if (head_mode != op_mode_q) begin
          state_d = DRAIN;
          err_d   = err_q | (phase_q != 2'd0);
        end else if (!busy && credit_ok) begin
          issue    = 1'b1;
          in_en_d  = 1'b1;
          yuv_in_d = head[7:0];
          rgb_in_d = head[23:0];
          if (!op_mode_q) phase_d = phase_q + 2'd1;
          if (closing) state_d = GAP;
        end
      end
      GAP: state_d = RUN;
      DRAIN: begin
        if ((pending_q == '0) && !busy) begin
          op_mode_d = ~op_mode_q;
          phase_d   = 2'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stray result with nothing outstanding is still queued but cannot underflow the count.
    pending_d = pending_q;
    if (out_valid && (pending_q != '0)) pending_d = pending_q - PW'(1);
    if (issue) pending_d = pending_d + add;
  end

  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    out_wr_d = out_wr_q;
    out_rd_d = out_rd_q;
    if (in_push)   in_wr_d  = in_wr_q + IN_ONE;
    if (issue)     in_rd_d  = in_rd_q + IN_ONE;
    if (out_valid) out_wr_d = out_wr_q + OUT_ONE;
    if (out_pop)   out_rd_d = out_rd_q + OUT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_mode_q <= 1'b0;
      in_en_q   <= 1'b0;
      yuv_in_q  <= '0;
      rgb_in_q  <= '0;
      err_q     <= 1'b0;
      phase_q   <= 2'd0;
      pending_q <= '0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_mode_q <= op_mode_d;
      in_en_q   <= in_en_d;
      yuv_in_q  <= yuv_in_d;
      rgb_in_q  <= rgb_in_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
    end
  end

  // Storage arrays carry data only and are left out of reset.
  always_ff @(posedge clk) begin
    if (in_push)   in_mem_q[in_wr_q[IAW-1:0]]   <= {s_mode, s_data};
    if (out_valid) out_mem_q[out_wr_q[OAW-1:0]] <= cap_data;
  end

  assign s_ready = !in_full;
  assign m_valid = !out_empty;
  assign m_data  = out_empty ? 24'h0 : out_mem_q[out_rd_q[OAW-1:0]];
  assign op_mode = op_mode_q;
  assign in_en   = in_en_q;
  assign yuv_in  = yuv_in_q;
  assign rgb_in  = rgb_in_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cte_stream_driver.sv
// Directed bench for cte_stream_driver with a small behavioural CTE model driving
// busy/out_valid and a scoreboard of hand-computed result words.
module tb_cte_stream_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_mode, m_ready;
  logic [23:0] s_data;
  logic        s_ready, m_valid, op_mode, in_en, err;
  logic [23:0] m_data, rgb_in;
  logic [7:0]  yuv_in;
  logic        busy = 1'b0, out_valid = 1'b0;
  logic [23:0] rgb_out = '0;
  logic [7:0]  yuv_out = '0;

  int checks = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, en_cnt = 0, consec = 0, bad_toggle = 0;
  int mq_due[$];
  logic [23:0] mq_dat[$];
  logic [23:0] rx[$];
  logic en_log[$];
  logic [1:0] m_phase = '0;
  logic m_mode = 1'b0, prev_en = 1'b0, tg_ok, tg_om;
  logic [7:0] m_u = '0, m_y0 = '0, m_v = '0;

  cte_stream_driver #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .op_mode(op_mode), .in_en(in_en), .yuv_in(yuv_in), .rgb_in(rgb_in), .busy(busy),
    .out_valid(out_valid), .rgb_out(rgb_out), .yuv_out(yuv_out), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] clamp8(input int x);
    if (x < 0) return 8'h00;
    if (x > 255) return 8'hFF;
    return 8'(x);
  endfunction

  function automatic logic [23:0] yuv2rgb(input logic [7:0] u, input logic [7:0] y, input logic [7:0] v);
    int du, dv;
    du = int'(u) - 128;
    dv = int'(v) - 128;
    return {clamp8(int'(y) + ((359 * dv) >>> 8)),
            clamp8(int'(y) - ((88 * du + 183 * dv) >>> 8)),
            clamp8(int'(y) + ((454 * du) >>> 8))};
  endfunction

  function automatic logic [7:0] rgb2y(input logic [23:0] p);
    return 8'((77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8);
  endfunction

  function automatic logic [7:0] rgb2c(input logic [23:0] p);
    return 8'(128 + (int'(p[7:0]) >> 1) - (int'(p[23:16]) >> 1));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sched(input logic [23:0] d);
    mq_due.push_back(cyc + 2);
    mq_dat.push_back(d);
  endtask

  // CTE model: mode 0 emits one RGB per 4:2:2 half-group, mode 1 emits two bytes per pixel.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      busy = 1'b0; out_valid = 1'b0; rgb_out = '0; yuv_out = '0;
      m_phase = '0; m_mode = 1'b0; busy_cnt = 0;
      mq_due.delete(); mq_dat.delete();
    end else begin
      cyc = cyc + 1;
      out_valid = 1'b0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        out_valid = 1'b1;
        rgb_out = op_mode ? 24'hA5A5A5 : mq_dat[0];
        yuv_out = op_mode ? mq_dat[0][7:0] : 8'h5A;
        void'(mq_due.pop_front());
        void'(mq_dat.pop_front());
      end
      if (busy_cnt > 0) busy_cnt--;
      if (op_mode != m_mode) begin
        m_mode = op_mode;
        m_phase = '0;
      end
      if (in_en) begin
        if (!op_mode) begin
          case (m_phase)
            2'd0: m_u = yuv_in;
            2'd1: m_y0 = yuv_in;
            2'd2: begin m_v = yuv_in; sched(yuv2rgb(m_u, m_y0, m_v)); end
            default: sched(yuv2rgb(m_u, yuv_in, m_v));
          endcase
          m_phase = m_phase + 2'd1;
        end else begin
          sched({16'h0, rgb2y(rgb_in)});
          sched({16'h0, rgb2c(rgb_in)});
          busy_cnt = 2;
        end
      end
      busy = (busy_cnt != 0);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (m_valid && m_ready) rx.push_back(m_data);
      en_log.push_back(in_en);
      if (in_en) en_cnt++;
      if (in_en && prev_en) consec++;
      prev_en = in_en;
    end
  end

  always @(posedge clk) begin
    tg_ok = !busy && (mq_due.size() == 0);
    tg_om = op_mode;
    #1;
    if (reset && (op_mode != tg_om) && !tg_ok) bad_toggle++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [23:0] d);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    s_valid = 1'b1; s_mode = mode; s_data = d;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check_eq("push_timeout", 32'(acc), 32'(1));
    s_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int g;
    g = 0;
    while (rx.size() < n && g < 300) begin step(1); g++; end
    step(6);
    check_eq("rx_count", 32'(rx.size()), 32'(n));
  endtask

  task automatic en_pattern(input string tag);
    int f;
    logic [5:0] pat;
    f = -1;
    pat = '0;
    for (int i = 0; i < en_log.size(); i++) if (en_log[i] && f < 0) f = i;
    if (f >= 0 && f + 6 <= en_log.size())
      for (int i = 0; i < 6; i++) pat = {pat[4:0], en_log[f+i]};
    check_eq(tag, 32'(pat), 32'(6'b111010));
  endtask

  task automatic rx_word(input string tag, input int idx, input logic [23:0] exp);
    if (idx < rx.size()) check_eq(tag, 32'(rx[idx]), 32'(exp));
    else check_eq(tag, 32'hFFFFFFFF, 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op_mode"}, 32'(op_mode), 32'(0));
    check_eq({tag, "_in_en"},   32'(in_en),   32'(0));
    check_eq({tag, "_yuv_in"},  32'(yuv_in),  32'(0));
    check_eq({tag, "_rgb_in"},  32'(rgb_in),  32'(0));
    check_eq({tag, "_s_ready"}, 32'(s_ready), 32'(1));
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    check_eq({tag, "_m_data"},  32'(m_data),  32'(0));
    check_eq({tag, "_err"},     32'(err),     32'(0));
  endtask

  task automatic test_yuv_group();
    rx.delete(); en_log.delete();
    push(1'b0, 24'h80); push(1'b0, 24'h50); push(1'b0, 24'h80); push(1'b0, 24'h60);
    wait_rx(2);
    rx_word("yuv_px0", 0, 24'h505050);
    rx_word("yuv_px1", 1, 24'h606060);
    en_pattern("yuv_en_pattern");
  endtask

  task automatic test_rgb();
    rx.delete(); consec = 0;
    push(1'b1, 24'hFF0000); push(1'b1, 24'h00FF00);
    wait_rx(4);
    rx_word("rgb_b0", 0, 24'h00004C);
    rx_word("rgb_b1", 1, 24'h000001);
    rx_word("rgb_b2", 2, 24'h000095);
    rx_word("rgb_b3", 3, 24'h000080);
    if (rx.size() >= 4) check_eq("rgb_upper", 32'((rx[0] | rx[1] | rx[2] | rx[3]) >> 8), 32'(0));
    check_eq("rgb_consec_en", 32'(consec), 32'(0));
    check_eq("rgb_op_mode", 32'(op_mode), 32'(1));
  endtask

  task automatic test_backpressure();
    logic [23:0] px [8];
    for (int i = 0; i < 8; i++) px[i] = {8'(i * 30), 8'(255 - i * 20), 8'(i * 17)};
    rx.delete(); m_ready = 1'b0; en_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) push(1'b1, px[i]);
      end
      begin
        step(40);
        check_eq("bp_issued", 32'(en_cnt), 32'(2));
        check_eq("bp_m_valid", 32'(m_valid), 32'(1));
        check_eq("bp_hold_data", 32'(m_data), 32'({16'h0, rgb2y(px[0])}));
        check_eq("bp_rx_none", 32'(rx.size()), 32'(0));
        m_ready = 1'b1;
      end
    join
    wait_rx(16);
    for (int i = 0; i < 8; i++) begin
      rx_word("bp_y", 2 * i, {16'h0, rgb2y(px[i])});
      rx_word("bp_c", 2 * i + 1, {16'h0, rgb2c(px[i])});
    end
    check_eq("bp_total_issued", 32'(en_cnt), 32'(8));
  endtask

  task automatic test_mode_switch();
    rx.delete(); bad_toggle = 0;
    check_eq("sw_err_before", 32'(err), 32'(0));
    push(1'b0, 24'h80); push(1'b0, 24'h40); push(1'b0, 24'h80); push(1'b0, 24'h20);
    push(1'b1, 24'h0000FF);
    wait_rx(4);
    rx_word("sw_px0", 0, 24'h404040);
    rx_word("sw_px1", 1, 24'h202020);
    rx_word("sw_y", 2, 24'h00001C);
    rx_word("sw_c", 3, 24'h0000FF);
    check_eq("sw_bad_toggle", 32'(bad_toggle), 32'(0));
    check_eq("sw_err", 32'(err), 32'(0));
    check_eq("sw_op_mode", 32'(op_mode), 32'(1));
  endtask

  task automatic test_illegal();
    rx.delete();
    push(1'b0, 24'h80); push(1'b0, 24'h70);
    push(1'b1, 24'h102030);
    wait_rx(2);
    rx_word("ill_y", 0, 24'h00001D);
    rx_word("ill_c", 1, 24'h000090);
    check_eq("ill_err_set", 32'(err), 32'(1));
    rx.delete(); en_log.delete();
    push(1'b0, 24'h80); push(1'b0, 24'h30); push(1'b0, 24'h80); push(1'b0, 24'h90);
    wait_rx(2);
    rx_word("ill_px0", 0, 24'h303030);
    rx_word("ill_px1", 1, 24'h909090);
    en_pattern("ill_en_pattern");
    check_eq("ill_err_sticky", 32'(err), 32'(1));
    check_eq("ill_bad_toggle", 32'(bad_toggle), 32'(0));
  endtask

  task automatic test_reset_mid();
    push(1'b0, 24'h80); push(1'b0, 24'h55);
    step(1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step(3);
    reset = 1'b1;
    rx.delete(); en_log.delete();
    step(2);
    push(1'b0, 24'h80); push(1'b0, 24'hA0); push(1'b0, 24'h80); push(1'b0, 24'hB0);
    wait_rx(2);
    rx_word("post_rst_px0", 0, 24'hA0A0A0);
    rx_word("post_rst_px1", 1, 24'hB0B0B0);
    en_pattern("post_rst_en_pattern");
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_mode = 1'b0; s_data = '0; m_ready = 1'b1;
    step(3);
    check_reset_outputs("rst");
    reset = 1'b1;
    step(2);
    test_yuv_group();
    test_rgb();
    test_backpressure();
    test_mode_switch();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
